pilha_retorno: RTL and testbench
================================

Name: pilha_retorno

Overview:
- Hardware LIFO stack that responds to the control unit's push/pop strobes.
- Stores return addresses for jal and returns them for jst; also stores register values for lstk and releases them for sstk.
- Sits beside the PC mux. Its top-of-stack output feeds PC mux input 2'b11 and the memory data mux.
- Source data is chosen by SelMuxPilha.

Parameters:
- WIDTH, 32, width of each stack entry and of the data ports.
- DEPTH, 16, number of entries; power of two, at least 2.
- NW, $clog2(DEPTH)+1, width of the occupancy count (derived, not overridable).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  push strobe from the control unit; sampled on the rising edge.
- pop  input  1  pop strobe from the control unit; sampled on the rising edge.
- SelMuxPilha  input  1  push source select: 0 = end_retorno, 1 = dado_reg.
- end_retorno  input  WIDTH  return address (PC value) to push.
- dado_reg  input  WIDTH  register-bank value to push.
- topo  output  WIDTH  current top entry; 0 when the stack is empty.
- nivel  output  NW  number of valid entries, 0..DEPTH.
- vazia  output  1  high when nivel == 0.
- cheia  output  1  high when nivel == DEPTH.
- overflow  output  1  sticky error: a push was dropped.
- underflow  output  1  sticky error: a pop was made on an empty stack.

Behaviour:
- Reset (synchronous, reset high at a rising edge):
  - nivel=0, topo=0, vazia=1, cheia=0, overflow=0, underflow=0.
  - push and pop in the same cycle are ignored.
  - Entry RAM contents are don't-care after reset.
- Strobe timing:
  - The control unit drives strobes on the falling edge; this block samples them on the next rising edge.
  - A strobe held high across N rising edges counts as N operations.
- topo is registered. It always equals the newest valid entry, updated at the same edge as the operation (visible one cycle after the strobe is sampled).
- Consumers read topo before or alongside pop:
  - In the jst state, PC loads topo at the same edge that pop is sampled, so the PC gets the pre-pop top.
- Push only, not full:
  - Entry nivel is written with the selected data; nivel increments.
  - topo = selected data.
- Push only, full:
  - Data is dropped; nivel and topo are unchanged; overflow is set to 1.
- Pop only, not empty:
  - nivel decrements.
  - topo = the entry below the old top, or 0 if the stack becomes empty.
- Pop only, empty:
  - nivel stays 0, topo stays 0; underflow is set to 1.
- Push and pop together:
  - Non-empty (including full): the top entry is replaced with the selected data; nivel unchanged; topo = new data; no overflow.
  - Empty: behaves as a push (nivel=1, topo=data); no underflow.
- Neither strobe: all state holds.
- overflow and underflow are sticky; only reset clears them. They do not block later operations.
- vazia and cheia are decoded from the registered nivel and have no extra latency.
- Wrap-around: the stack pointer never wraps. Attempts beyond DEPTH or below 0 are handled only by the full/empty rules above.
- SelMuxPilha and the data inputs are don't-care when push is low.
- Implementation: single read/write entry array plus a registered top copy. No combinational path from push/pop to topo.

Test Plan:
- Reset, then push end_retorno=0x00000010 with SelMuxPilha=0 -> next cycle topo=0x10, nivel=1, vazia=0.
- Push 0x10, 0x20, 0x30, then pop three times -> topo sequence 0x20, 0x10, 0; nivel 2, 1, 0; vazia=1; underflow=0.
- Pop on an empty stack after reset -> underflow=1, nivel=0, topo=0. A following push of 0x5 works (topo=5); underflow stays 1.
- Fill 16 entries (values 1..16), then push 0x99 -> cheia=1, overflow=1, topo=16, nivel=16. Then push+pop with dado_reg=0xAB, SelMuxPilha=1 -> topo=0xAB, nivel=16, no extra flag change.
- With nivel=3, assert push+pop with end_retorno=0x77 -> nivel=3, topo=0x77; a later pop exposes the original second entry.
- With nivel=5, assert reset together with push -> nivel=0, topo=0, overflow=0, underflow=0; the push is ignored.

Source files
------------

// File: rtl/pilha_retorno.sv
// Hardware LIFO for return addresses (jal/jst) and register values (lstk/sstk).
// The top entry is kept in a register so consumers see it with no read latency.
module pilha_retorno #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         SelMuxPilha,
  input  logic [WIDTH-1:0]             end_retorno,
  input  logic [WIDTH-1:0]             dado_reg,
  output logic [WIDTH-1:0]             topo,
  output logic [$clog2(DEPTH):0]       nivel,
  output logic                         vazia,
  output logic                         cheia,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned NW = $clog2(DEPTH) + 1;
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] dado_sel;
  logic [NW-1:0]    nivel_n;
  logic [WIDTH-1:0] topo_n;
  logic             overflow_n;
  logic             underflow_n;
  logic             vazia_n;
  logic             cheia_n;
  logic             we;
  logic [AW-1:0]    waddr;
  logic             empty;
  logic             full;

  assign dado_sel = SelMuxPilha ? dado_reg : end_retorno;
  assign empty    = (nivel == NW'(0));
  assign full     = (nivel == NW'(DEPTH));

  // Next-state decode for one push/pop operation.
  always_comb begin
    nivel_n     = nivel;
    topo_n      = topo;
    overflow_n  = overflow;
    underflow_n = underflow;
    we          = 1'b0;
    waddr       = AW'(nivel);
    if (push && pop) begin
      we     = 1'b1;
      topo_n = dado_sel;
      if (empty) begin
        waddr   = AW'(0);
        nivel_n = NW'(1);
      end else begin
        waddr   = AW'(nivel - NW'(1));
      end
    end else if (push) begin
      if (full) begin
        overflow_n = 1'b1;
      end else begin
        we      = 1'b1;
        nivel_n = nivel + NW'(1);
        topo_n  = dado_sel;
      end
    end else if (pop) begin
      if (empty) begin
        underflow_n = 1'b1;
      end else begin
        nivel_n = nivel - NW'(1);
        topo_n  = (nivel == NW'(1)) ? '0 : mem[AW'(nivel - NW'(2))];
      end
    end
    vazia_n = (nivel_n == NW'(0));
    cheia_n = (nivel_n == NW'(DEPTH));
  end

  // Control/status registers; flags decoded from the next level to stay aligned with nivel.
  always_ff @(posedge clk) begin
    if (reset) begin
      nivel     <= '0;
      topo      <= '0;
      vazia     <= 1'b1;
      cheia     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      nivel     <= nivel_n;
      topo      <= topo_n;
      vazia     <= vazia_n;
      cheia     <= cheia_n;
      overflow  <= overflow_n;
      underflow <= underflow_n;
    end
  end

  // Entry array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem[waddr] <= dado_sel;
    end
  end

endmodule

// File: tb/tb_pilha_retorno.sv
// Directed self-checking bench for pilha_retorno (WIDTH=32, DEPTH=16).
module tb_pilha_retorno;

  logic        clk;
  logic        reset;
  logic        push;
  logic        pop;
  logic        SelMuxPilha;
  logic [31:0] end_retorno;
  logic [31:0] dado_reg;
  logic [31:0] topo;
  logic [4:0]  nivel;
  logic        vazia;
  logic        cheia;
  logic        overflow;
  logic        underflow;

  int n_cmp;
  int n_err;

  // status = {topo, nivel, vazia, cheia, overflow, underflow}
  logic [40:0] status;
  assign status = {topo, nivel, vazia, cheia, overflow, underflow};

  pilha_retorno #(.WIDTH(32), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .SelMuxPilha(SelMuxPilha),
    .end_retorno(end_retorno), .dado_reg(dado_reg), .topo(topo), .nivel(nivel),
    .vazia(vazia), .cheia(cheia), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One operation: drive at falling edge, sampled at the next rising edge, then release.
  task automatic step(input logic rst, input logic ps, input logic pp, input logic sel,
                      input logic [31:0] er, input logic [31:0] dr);
    @(negedge clk);
    reset = rst; push = ps; pop = pp; SelMuxPilha = sel; end_retorno = er; dado_reg = dr;
    @(posedge clk);
    #1;
    reset = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (status !== {32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_state got=%h exp=%h", status, {32'h0, 5'd0, 4'b1000});
    end
  endtask

  task automatic test_push_single;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEAD);
    n_cmp++;
    if (status !== {32'h10, 5'd1, 4'b0000}) begin
      n_err++; $display("FAIL push_single got=%h exp=%h", status, {32'h10, 5'd1, 4'b0000});
    end
  endtask

  task automatic test_push_pop_seq;
    logic [31:0] exp_t [3];
    exp_t[0] = 32'h20; exp_t[1] = 32'h10; exp_t[2] = 32'h0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
    n_cmp++;
    if (status !== {32'h30, 5'd3, 4'b0000}) begin
      n_err++; $display("FAIL seq_push3 got=%h exp=%h", status, {32'h30, 5'd3, 4'b0000});
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      n_cmp++;
      if (status !== {exp_t[i], 5'(2 - i), (i == 2), 3'b000}) begin
        n_err++;
        $display("FAIL seq_pop%0d got=%h exp=%h", i, status, {exp_t[i], 5'(2 - i), (i == 2), 3'b000});
      end
    end
  endtask

  task automatic test_underflow;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (status !== {32'h0, 5'd0, 4'b1001}) begin
      n_err++; $display("FAIL underflow_pop got=%h exp=%h", status, {32'h0, 5'd0, 4'b1001});
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h5, 32'h0);
    n_cmp++;
    if (status !== {32'h5, 5'd1, 4'b0001}) begin
      n_err++; $display("FAIL underflow_push got=%h exp=%h", status, {32'h5, 5'd1, 4'b0001});
    end
  endtask

  task automatic test_overflow;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'(i), 32'h0);
    n_cmp++;
    if (status !== {32'd16, 5'd16, 4'b0100}) begin
      n_err++; $display("FAIL fill16 got=%h exp=%h", status, {32'd16, 5'd16, 4'b0100});
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h99, 32'h0);
    n_cmp++;
    if (status !== {32'd16, 5'd16, 4'b0110}) begin
      n_err++; $display("FAIL overflow_drop got=%h exp=%h", status, {32'd16, 5'd16, 4'b0110});
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h55, 32'hAB);
    n_cmp++;
    if (status !== {32'hAB, 5'd16, 4'b0110}) begin
      n_err++; $display("FAIL full_replace got=%h exp=%h", status, {32'hAB, 5'd16, 4'b0110});
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (status !== {32'd15, 5'd15, 4'b0010}) begin
      n_err++; $display("FAIL full_pop got=%h exp=%h", status, {32'd15, 5'd15, 4'b0010});
    end
  endtask

  task automatic test_replace;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h11, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h22);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h33, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h77, 32'hEE);
    n_cmp++;
    if (status !== {32'h77, 5'd3, 4'b0000}) begin
      n_err++; $display("FAIL replace got=%h exp=%h", status, {32'h77, 5'd3, 4'b0000});
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (status !== {32'h22, 5'd2, 4'b0000}) begin
      n_err++; $display("FAIL replace_pop got=%h exp=%h", status, {32'h22, 5'd2, 4'b0000});
    end
  endtask

  task automatic test_pushpop_empty;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h42, 32'h0);
    n_cmp++;
    if (status !== {32'h42, 5'd1, 4'b0000}) begin
      n_err++; $display("FAIL pushpop_empty got=%h exp=%h", status, {32'h42, 5'd1, 4'b0000});
    end
  endtask

  // Strobe held high across several rising edges counts once per edge.
  task automatic test_back_to_back;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    push = 1'b1; SelMuxPilha = 1'b0; end_retorno = 32'hA1;
    @(negedge clk); end_retorno = 32'hA2;
    @(negedge clk); end_retorno = 32'hA3;
    @(negedge clk); push = 1'b0;
    n_cmp++;
    if (status !== {32'hA3, 5'd3, 4'b0000}) begin
      n_err++; $display("FAIL held_push got=%h exp=%h", status, {32'hA3, 5'd3, 4'b0000});
    end
    pop = 1'b1;
    @(negedge clk);
    @(negedge clk); pop = 1'b0;
    n_cmp++;
    if (status !== {32'hA1, 5'd1, 4'b0000}) begin
      n_err++; $display("FAIL held_pop got=%h exp=%h", status, {32'hA1, 5'd1, 4'b0000});
    end
  endtask

  task automatic test_reset_with_push;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'(32'h100 + i), 32'h0);
    n_cmp++;
    if (status !== {32'h104, 5'd5, 4'b0001}) begin
      n_err++; $display("FAIL pre_reset got=%h exp=%h", status, {32'h104, 5'd5, 4'b0001});
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h999, 32'h0);
    n_cmp++;
    if (status !== {32'h0, 5'd0, 4'b1000}) begin
      n_err++; $display("FAIL reset_push got=%h exp=%h", status, {32'h0, 5'd0, 4'b1000});
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; push = 1'b0; pop = 1'b0; SelMuxPilha = 1'b0;
    end_retorno = '0; dado_reg = '0;
    test_reset();
    test_push_single();
    test_push_pop_seq();
    test_underflow();
    test_overflow();
    test_replace();
    test_pushpop_empty();
    test_back_to_back();
    test_reset_with_push();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
